quad_enc_rx: RTL and testbench
==============================

Name: quad_enc_rx

Overview:
- Receiver for the differential quadrature encoder interface (ENC_P/ENC_N, channels A=bit0, B=bit1, Z=bit2). The bench side of this interface is the encoder model that drives these lines.
- Synchronises and glitch-filters the channels, checks differential integrity, and decodes 4x quadrature into a signed position.
- Measures the step period in CLK cycles.
- Emits one LINE_TRIG per DIV forward steps, with backlash compensation. LINE_TRIG starts a sensor line exposure in top.

Parameters:
FILT_LEN, 4, consecutive stable cycles required before a filtered channel changes (>=1)
POS_W, 32, position counter width (signed)
PER_W, 24, period counter width
DIV_W, 16, line divider width
ERR_W, 8, illegal-transition counter width

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
ENC_P  in  3  encoder positive lines {Z,B,A}
ENC_N  in  3  encoder negative lines {Z,B,A}
DIV  in  DIV_W  forward steps per line; 0 is treated as 1
INDEX_CLR_EN  in  1  allow Z rising edge to clear POS
POS  out  POS_W  signed position
DIR  out  1  last step direction, 1=forward
STEP  out  1  one-cycle pulse per valid step
PERIOD  out  PER_W  cycles between the last two valid steps
PERIOD_VLD  out  1  one-cycle pulse when PERIOD is updated
STALL  out  1  period counter saturated
LINE_TRIG  out  1  one-cycle line start pulse
ERR_CNT  out  ERR_W  saturating count of illegal transitions
FAULT  out  1  differential fault, level

Behaviour:
- Reset (async, any time, including mid-operation): every output is 0, the filtered state is 00, and the internal counters are cleared.
- Sync: 2-FF synchroniser on ENC_P and ENC_N per bit.
- Filter: the per-channel filtered value takes the synced P value on the FILT_LEN-th consecutive cycle in which that value differs from the current filtered value. Any shorter excursion restarts the count.
- Latency: an edge that stays stable is followed by STEP exactly 2+FILT_LEN+1 cycles after the first CLK edge that samples it.
- Fault detection: when synced P==N on any channel for FILT_LEN consecutive cycles, FAULT=1.
  - FAULT clears on the first cycle all channels have P!=N.
  - While FAULT=1, the filtered values are frozen and no STEP, ERR or trigger is generated.
- Decode, with state {A,B}:
  - Forward sequence is 00->10->11->01->00: POS+1, DIR=1.
  - The reverse sequence gives POS-1, DIR=0.
  - POS wraps modulo 2^POS_W.
  - Both A and B changing in the same filtered cycle: ERR_CNT+1 (saturating at all-ones), no STEP, and the new state is adopted.
- Index: when the filtered Z has a rising edge and INDEX_CLR_EN=1, POS=0. If a step occurs in the same cycle, POS=+1 or -1 (clear first, then apply the step). The line accumulator is unaffected.
- Period measurement:
  - A free counter increments every cycle and saturates at 2^PER_W-1, which sets STALL=1.
  - On a step, PERIOD = cycles since the previous step, PERIOD_VLD pulses, and the counter restarts at 1.
  - The first step after reset gives no PERIOD_VLD.
  - A step while STALL=1 clears STALL, gives no PERIOD_VLD, and leaves PERIOD unchanged.
  - A direction reversal is still measured normally.
- Line accumulator (ACC, signed, DIV_W+1 bits):
  - Forward step: when ACC+1 >= max(DIV,1), LINE_TRIG pulses in the same cycle as STEP and ACC=0; otherwise ACC+1.
  - Backward step: ACC-1, floored at -(2^DIV_W-1), so backlash must be re-traversed before triggering resumes.
  - A DIV change takes effect at the next forward step, using the >= comparison.
- State machine (per reset): INIT (no previous step) -> RUN on the first step -> STALLED on counter saturation -> RUN on the next step. FAULT overrides decoding in any state without changing it.

Decomposition:
- Package quad_enc_pkg holds the default widths and a typedef enum for the quad state (S00, S10, S11, S01).
- Package function step_dir(prev, cur) returns NONE/FWD/REV/ILLEGAL.
- Sub-module quad_enc_filt (synchroniser, glitch filter and per-channel P==N fault) is instantiated 3 times.

Test Plan:
1. Forward: DIV=4, 8 edges, toggling A then B alternately every 2000 cycles from 00 -> POS=8, DIR=1, 2 LINE_TRIG (on steps 4 and 8), PERIOD=2000 with PERIOD_VLD on steps 2..8.
2. Backlash: DIV=4, 2 forward, 3 reverse, then forward steps -> POS=-1 after the reverse steps; the first LINE_TRIG comes on the 5th forward step (ACC -1 -> 4).
3. Glitch: A pulse lasting FILT_LEN-1 cycles -> no STEP, POS unchanged. Then a stable edge -> STEP at exactly 2+FILT_LEN+1 cycles.
4. Illegal: A and B toggled together -> ERR_CNT=1, no STEP, POS unchanged. 300 such events -> ERR_CNT=255.
5. Stall: PER_W=12, no edges for 5000 cycles -> STALL=1. The next edge -> STALL=0, STEP=1, PERIOD_VLD=0. The following edge after 100 cycles -> PERIOD=100.
6. Index, fault and reset:
   - Z rising edge with INDEX_CLR_EN=1 at POS=37 -> POS=0.
   - ENC_N[0]=ENC_P[0] for FILT_LEN cycles -> FAULT=1 and A edges are ignored.
   - RST pulse mid-motion -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/quad_enc_rx_pkg.sv
// quad_enc_pkg: default widths, quadrature state encoding and step classification.
package quad_enc_pkg;
    localparam int FILT_LEN_DEF = 4;
    localparam int POS_W_DEF    = 32;
    localparam int PER_W_DEF    = 24;
    localparam int DIV_W_DEF    = 16;
    localparam int ERR_W_DEF    = 8;
    typedef enum logic [1:0] {S00 = 2'b00, S10 = 2'b10, S11 = 2'b11, S01 = 2'b01} quad_t;
    typedef enum logic [1:0] {NONE, FWD, REV, ILLEGAL} step_t;
    // {A,B} maps to a phase index {B, A^B}; the phase difference classifies the move
    function automatic step_t step_dir(quad_t prev, quad_t cur);
        logic [1:0] p;
        logic [1:0] c;
        logic [1:0] d;
        p = prev;
        c = cur;
        d = {c[0], ^c} - {p[0], ^p};
        return d == 2'd1 ? FWD : d == 2'd3 ? REV : d == 2'd2 ? ILLEGAL : NONE;
    endfunction
endpackage

// File: rtl/quad_enc_rx_if.sv
// quad_enc_rx_if: differential encoder lines {Z,B,A}; the encoder drives the master side.
interface quad_enc_rx_if;
    logic [2:0] ENC_P;
    logic [2:0] ENC_N;
    modport master (output ENC_P, ENC_N);
    modport slave (input ENC_P, ENC_N);
endinterface

// File: rtl/quad_enc_rx_filt.sv
// quad_enc_filt: per-channel 2-FF synchroniser, glitch filter and P==N detector.
module quad_enc_filt import quad_enc_pkg::*; #(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic p,
    input  logic n,
    input  logic freeze,
    output logic filt,
    output logic eq,
    output logic eq_long
);
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [1:0] p_sync;
    logic [1:0] n_sync;
    logic [CW-1:0] chg_cnt;
    logic [CW-1:0] eq_cnt;
    logic p_s;
    logic take;
    assign p_s = p_sync[1];
    assign eq = p_s == n_sync[1];
    assign eq_long = eq && eq_cnt == CW'(FILT_LEN - 1);
    assign take = !freeze && p_s != filt && chg_cnt == CW'(FILT_LEN - 1);
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            p_sync  <= '0;
            n_sync  <= '0;
            chg_cnt <= '0;
            eq_cnt  <= '0;
            filt    <= 1'b0;
        end else begin
            p_sync  <= {p_sync[0], p};
            n_sync  <= {n_sync[0], n};
            eq_cnt  <= !eq ? '0 : eq_cnt == CW'(FILT_LEN - 1) ? eq_cnt : eq_cnt + 1'b1;
            chg_cnt <= freeze || p_s == filt || take ? '0 : chg_cnt + 1'b1;
            if (take) filt <= p_s;
        end
endmodule

// File: rtl/quad_enc_rx.sv
// quad_enc_rx: differential quadrature receiver with 4x decode, period
// measurement, backlash-compensated line trigger and differential fault detection.
module quad_enc_rx import quad_enc_pkg::*; #(
    parameter int FILT_LEN = FILT_LEN_DEF,
    parameter int POS_W    = POS_W_DEF,
    parameter int PER_W    = PER_W_DEF,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int ERR_W    = ERR_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    quad_enc_rx_if.slave            enc,
    input  logic [DIV_W-1:0]        DIV,
    input  logic                    INDEX_CLR_EN,
    output logic signed [POS_W-1:0] POS,
    output logic                    DIR,
    output logic                    STEP,
    output logic [PER_W-1:0]        PERIOD,
    output logic                    PERIOD_VLD,
    output logic                    STALL,
    output logic                    LINE_TRIG,
    output logic [ERR_W-1:0]        ERR_CNT,
    output logic                    FAULT
);
    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;
    localparam logic [PER_W-1:0] PER_MAX = '1;
    localparam logic signed [DIV_W:0] ACC_MIN = {1'b1, DIV_W'(1)};
    logic [2:0] filt;
    logic [2:0] eq;
    logic [2:0] eq_long;
    logic [2:0] cur;
    logic [2:0] prev;
    logic [1:0] state;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] per_nxt;
    logic signed [DIV_W:0] acc;
    logic signed [DIV_W+1:0] acc_inc;
    logic [DIV_W-1:0] div_eff;
    logic [POS_W-1:0] pos_delta;
    step_t sd;
    logic step_ok;
    logic fwd;
    logic trig_ok;
    logic ill;
    logic idx_clr;
    for (genvar i = 0; i < 3; i++) begin : g_ch
        quad_enc_filt #(.FILT_LEN(FILT_LEN)) u_filt (
            .CLK(CLK),
            .RST(RST),
            .p(enc.ENC_P[i]),
            .n(enc.ENC_N[i]),
            .freeze(FAULT),
            .filt(filt[i]),
            .eq(eq[i]),
            .eq_long(eq_long[i])
        );
    end
    // decode compares the registered filtered state against its previous value
    assign sd = step_dir(quad_t'({prev[0], prev[1]}), quad_t'({cur[0], cur[1]}));
    assign fwd = sd == FWD;
    assign step_ok = !FAULT && (sd == FWD || sd == REV);
    assign ill = !FAULT && sd == ILLEGAL;
    assign idx_clr = !FAULT && INDEX_CLR_EN && cur[2] && !prev[2];
    assign div_eff = DIV == '0 ? DIV_W'(1) : DIV;
    assign acc_inc = {acc[DIV_W], acc} + 1'b1;
    assign trig_ok = step_ok && fwd && acc_inc >= $signed({2'b00, div_eff});
    assign pos_delta = !step_ok ? '0 : fwd ? POS_W'(1) : '1;
    assign per_nxt = step_ok ? PER_W'(1) : per_cnt == PER_MAX ? per_cnt : per_cnt + 1'b1;
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            cur        <= '0;
            prev       <= '0;
            state      <= ST_INIT;
            per_cnt    <= '0;
            acc        <= '0;
            POS        <= '0;
            DIR        <= 1'b0;
            STEP       <= 1'b0;
            PERIOD     <= '0;
            PERIOD_VLD <= 1'b0;
            STALL      <= 1'b0;
            LINE_TRIG  <= 1'b0;
            ERR_CNT    <= '0;
            FAULT      <= 1'b0;
        end else begin
            cur        <= filt;
            prev       <= cur;
            FAULT      <= FAULT ? |eq : |eq_long;
            STEP       <= step_ok;
            LINE_TRIG  <= trig_ok;
            POS        <= (idx_clr ? '0 : POS) + pos_delta;
            per_cnt    <= per_nxt;
            STALL      <= per_nxt == PER_MAX;
            PERIOD_VLD <= step_ok && state == ST_RUN;
            state      <= step_ok ? ST_RUN : state == ST_RUN && per_nxt == PER_MAX ? ST_STALLED : state;
            if (step_ok) DIR <= fwd;
            if (step_ok && state == ST_RUN) PERIOD <= per_cnt;
            if (ill && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
            // backward steps build up debt that forward motion must repay before the next line
            if (step_ok) acc <= trig_ok ? '0 : fwd ? acc + 1'b1 : acc == ACC_MIN ? acc : acc - 1'b1;
        end
endmodule

// File: tb/tb_quad_enc_rx.sv
// tb_quad_enc_rx: directed vector table plus hand-written corner sequences for quad_enc_rx.
module tb_quad_enc_rx;
    localparam int FL = 4;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [15:0] DIV = 16'd4;
    logic INDEX_CLR_EN = 1'b1;
    logic signed [31:0] POS;
    logic DIR, STEP, PERIOD_VLD, STALL, LINE_TRIG, FAULT;
    logic [11:0] PERIOD;
    logic [7:0] ERR_CNT;
    quad_enc_rx_if bus();
    quad_enc_rx #(.FILT_LEN(FL), .PER_W(12)) dut (
        .CLK(CLK), .RST(RST), .enc(bus), .DIV(DIV), .INDEX_CLR_EN(INDEX_CLR_EN),
        .POS(POS), .DIR(DIR), .STEP(STEP), .PERIOD(PERIOD), .PERIOD_VLD(PERIOD_VLD),
        .STALL(STALL), .LINE_TRIG(LINE_TRIG), .ERR_CNT(ERR_CNT), .FAULT(FAULT)
    );
    always #5 CLK = ~CLK;

    typedef struct {
        logic rst; logic [2:0] enc; int div; int gap;
        int pos; logic dir; logic trig; logic vld; int period;
    } vec_t;
    vec_t tab [24];
    int total = 0;
    int passed = 0;
    int nstep;
    int lat;
    logic [2:0] enc = 3'b000;
    logic [2:0] fmask = 3'b000;
    longint s_pos, s_period;
    logic s_dir, s_trig, s_vld, s_stall;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask
    task automatic put(input logic [2:0] v);
        @(negedge CLK);
        enc = v;
        bus.ENC_P = v;
        bus.ENC_N = ~v ^ fmask;
    endtask
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
            if (STEP) begin
                nstep++;
                s_pos = POS; s_dir = DIR; s_trig = LINE_TRIG;
                s_vld = PERIOD_VLD; s_period = PERIOD; s_stall = STALL;
            end
        end
    endtask
    task automatic move(input logic [2:0] v, input int n);
        put(v);
        run(n);
    endtask
    function automatic logic [2:0] fstep(input logic [2:0] e);
        return {e[2], e[0], ~e[1]};
    endfunction
    task automatic chk_zero(input string nm);
        chk(nm, longint'({POS, DIR, STEP, PERIOD, PERIOD_VLD, STALL, LINE_TRIG, ERR_CNT, FAULT}), 0);
    endtask

    initial begin
        bus.ENC_P = 3'b000;
        bus.ENC_N = 3'b111;
        tab[0]  = '{1'b1, 3'b001, 4, 2000, 1, 1'b1, 1'b0, 1'b0, 0};
        tab[1]  = '{1'b0, 3'b011, 4, 2000, 2, 1'b1, 1'b0, 1'b1, 2000};
        tab[2]  = '{1'b0, 3'b010, 4, 2000, 3, 1'b1, 1'b0, 1'b1, 2000};
        tab[3]  = '{1'b0, 3'b000, 4, 2000, 4, 1'b1, 1'b1, 1'b1, 2000};
        tab[4]  = '{1'b0, 3'b001, 4, 2000, 5, 1'b1, 1'b0, 1'b1, 2000};
        tab[5]  = '{1'b0, 3'b011, 4, 2000, 6, 1'b1, 1'b0, 1'b1, 2000};
        tab[6]  = '{1'b0, 3'b010, 4, 2000, 7, 1'b1, 1'b0, 1'b1, 2000};
        tab[7]  = '{1'b0, 3'b000, 4, 2000, 8, 1'b1, 1'b1, 1'b1, 2000};
        tab[8]  = '{1'b1, 3'b001, 4, 50, 1, 1'b1, 1'b0, 1'b0, 0};
        tab[9]  = '{1'b0, 3'b011, 4, 50, 2, 1'b1, 1'b0, 1'b1, 50};
        tab[10] = '{1'b0, 3'b001, 4, 50, 1, 1'b0, 1'b0, 1'b1, 50};
        tab[11] = '{1'b0, 3'b000, 4, 50, 0, 1'b0, 1'b0, 1'b1, 50};
        tab[12] = '{1'b0, 3'b010, 4, 50, -1, 1'b0, 1'b0, 1'b1, 50};
        tab[13] = '{1'b0, 3'b000, 4, 50, 0, 1'b1, 1'b0, 1'b1, 50};
        tab[14] = '{1'b0, 3'b001, 4, 50, 1, 1'b1, 1'b0, 1'b1, 50};
        tab[15] = '{1'b0, 3'b011, 4, 50, 2, 1'b1, 1'b0, 1'b1, 50};
        tab[16] = '{1'b0, 3'b010, 4, 50, 3, 1'b1, 1'b0, 1'b1, 50};
        tab[17] = '{1'b0, 3'b000, 4, 50, 4, 1'b1, 1'b1, 1'b1, 50};
        tab[18] = '{1'b0, 3'b001, 0, 50, 5, 1'b1, 1'b1, 1'b1, 50};
        tab[19] = '{1'b0, 3'b011, 0, 50, 6, 1'b1, 1'b1, 1'b1, 50};
        tab[20] = '{1'b0, 3'b010, 4, 50, 7, 1'b1, 1'b0, 1'b1, 50};
        tab[21] = '{1'b0, 3'b000, 4, 50, 8, 1'b1, 1'b0, 1'b1, 50};
        tab[22] = '{1'b0, 3'b001, 4, 50, 9, 1'b1, 1'b0, 1'b1, 50};
        tab[23] = '{1'b0, 3'b011, 2, 50, 10, 1'b1, 1'b1, 1'b1, 50};
        repeat (3) @(posedge CLK);
        #1 chk_zero("reset_outputs");
        @(negedge CLK) RST = 1'b0;
        run(10);

        // forward, backlash, DIV=0 and DIV change
        foreach (tab[r]) begin
            if (tab[r].rst) begin
                @(negedge CLK) RST = 1'b1;
                @(negedge CLK) RST = 1'b0;
                run(10);
            end
            DIV = 16'(tab[r].div);
            nstep = 0;
            move(tab[r].enc, tab[r].gap);
            chk($sformatf("row%0d_steps", r), nstep, 1);
            chk($sformatf("row%0d_pos", r), s_pos, tab[r].pos);
            chk($sformatf("row%0d_dir", r), s_dir, tab[r].dir);
            chk($sformatf("row%0d_trig", r), s_trig, tab[r].trig);
            chk($sformatf("row%0d_vld", r), s_vld, tab[r].vld);
            if (tab[r].vld) chk($sformatf("row%0d_period", r), s_period, tab[r].period);
        end

        // glitch of FILT_LEN-1 cycles is rejected, then a stable edge has fixed latency
        DIV = 16'd4;
        nstep = 0;
        put(3'b010);
        run(FL - 1);
        move(3'b011, 30);
        chk("glitch_steps", nstep, 0);
        chk("glitch_pos", POS, 10);
        put(3'b010);
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(posedge CLK); #1;
            if (STEP) lat = k;
        end
        chk("latency", lat, 2 + FL + 1);
        chk("latency_pos", POS, 11);
        run(20);

        // illegal double transitions
        nstep = 0;
        move(3'b001, 20);
        chk("ill_err1", ERR_CNT, 1);
        chk("ill_pos1", POS, 11);
        for (int k = 0; k < 299; k++) move(enc ^ 3'b011, 12);
        chk("ill_err_sat", ERR_CNT, 255);
        chk("ill_steps", nstep, 0);
        chk("ill_pos", POS, 11);

        // stall and recovery
        nstep = 0;
        move(3'b000, 60);
        chk("stall_a_steps", nstep, 1);
        nstep = 0;
        move(3'b001, 5000);
        chk("stall_b_vld", s_vld, 1);
        chk("stall_b_period", s_period, 60);
        chk("stall_set", STALL, 1);
        chk("stall_period_hold", PERIOD, 60);
        nstep = 0;
        move(3'b011, 100);
        chk("stall_c_steps", nstep, 1);
        chk("stall_c_stall", s_stall, 0);
        chk("stall_c_vld", s_vld, 0);
        chk("stall_c_period", s_period, 60);
        move(3'b010, 100);
        chk("stall_d_vld", s_vld, 1);
        chk("stall_d_period", s_period, 100);

        // index clear
        put(3'b000);
        RST = 1'b1;
        @(negedge CLK) RST = 1'b0;
        run(10);
        nstep = 0;
        for (int k = 0; k < 37; k++) move(fstep(enc), 12);
        chk("idx_steps", nstep, 37);
        chk("idx_pos37", POS, 37);
        nstep = 0;
        move(enc | 3'b100, 20);
        chk("idx_clear_steps", nstep, 0);
        chk("idx_clear_pos", POS, 0);
        move(enc & 3'b011, 20);
        move(fstep(enc) | 3'b100, 20);
        chk("idx_step_same_cycle", POS, 1);
        move(enc & 3'b011, 20);
        INDEX_CLR_EN = 1'b0;
        move(enc | 3'b100, 20);
        chk("idx_disabled", POS, 1);
        INDEX_CLR_EN = 1'b1;

        // differential fault on channel A
        fmask = 3'b001;
        move(enc, 20);
        chk("fault_set", FAULT, 1);
        nstep = 0;
        move(enc ^ 3'b001, 30);
        move(enc ^ 3'b001, 30);
        chk("fault_steps", nstep, 0);
        chk("fault_pos", POS, 1);
        chk("fault_err", ERR_CNT, 0);
        fmask = 3'b000;
        move(enc, 20);
        chk("fault_clear", FAULT, 0);

        // asynchronous reset in the middle of a step
        put(fstep(enc));
        run(4);
        chk("pre_reset_pos", POS, 1);
        #2 RST = 1'b1;
        #1 chk_zero("async_reset");
        @(negedge CLK) RST = 1'b0;
        run(5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
